fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined MIPS32 core, directly upstream of the IF/ID pipeline register. Owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents `IR`/`PC`/`if_valid` for IF/ID to capture. It holds an accepted instruction while the pipeline is stalled, and discards in-flight fetches on a branch or jump redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `NOP_INSTR`, 32'h0000_0000, value driven on `IR` when `if_valid`=0
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  high when IF/ID will not capture this cycle
- `redirect`  in  1  taken branch/jump from later stage
- `redirect_pc`  in  32  target address for `redirect`
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  word address of request
- `imem_ack`  in  1  `imem_rdata` valid this cycle; completes request
- `imem_rdata`  in  32  instruction word
- `IR`  out  32  fetched instruction to IF/ID
- `PC`  out  32  fetch address + 4 to IF/ID
- `if_valid`  out  1  `IR`/`PC` carry a real instruction

## Operation
- State is `pc_q`, `pend_q`, buffer `buf_ir`/`buf_pc`, and FSM {IDLE, FETCH, HOLD, DROP}.
- Memory protocol:
  - `imem_req`=1 with `imem_addr` stable until the cycle `imem_ack`=1.
  - Ack may arrive in the first request cycle (zero wait).
  - A request is never withdrawn.
- Redirect target: `redirect_pc[1:0]` is forced to 00.
- PC arithmetic is 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- IDLE: `imem_req`=0. Go to FETCH on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=`pc_q`.
  - `redirect`, ack: `pc_q`←target, stay FETCH. Outputs invalid.
  - `redirect`, no ack: `pend_q`←target, go DROP.
  - ack, no stall: outputs `IR`=`imem_rdata`, `PC`=`pc_q`+4, `if_valid`=1. `pc_q`←`pc_q`+4.
  - ack, stall: same outputs. `buf_ir`/`buf_pc` ← `imem_rdata`/`pc_q`+4, `pc_q`←`pc_q`+4, go HOLD.
  - no ack: stay. Outputs invalid.
- HOLD: `imem_req`=0. Outputs `IR`=`buf_ir`, `PC`=`buf_pc`, `if_valid`=1.
  - `redirect`: `pc_q`←target, go FETCH. The buffer is dropped and outputs are invalid that cycle.
  - no stall: go FETCH. IF/ID has consumed the buffer.
  - stall: stay.
- DROP: `imem_req`=1, `imem_addr`=`pc_q` (old address). Outputs invalid.
  - `redirect` again: `pend_q`←new target.
  - ack: `pc_q`←`pend_q` (or the new target if `redirect` is also asserted this cycle), go FETCH. `imem_rdata` is discarded.
- Invalid outputs are `IR`=`NOP_INSTR`, `PC`=0, `if_valid`=0.
- Priority: `redirect` > `stall`.

## Timing
- Reset (asynchronous, `reset`=0):
  - State IDLE; `pc_q`=`RESET_PC`; `pend_q`, `buf_ir`, `buf_pc` = 0.
  - Outputs: `imem_req`=0, `IR`=`NOP_INSTR`, `PC`=0, `if_valid`=0.
- After `reset` rises:
  - First edge: IDLE→FETCH.
  - `imem_req` first asserts in the following cycle with `imem_addr`=`RESET_PC`.
- Reset asserted mid-request (FETCH or DROP) returns immediately to the reset values. Any later ack is ignored because the block is in IDLE.
- Zero-wait memory with no stall gives one instruction per cycle.
- `IR`/`PC`/`if_valid` are combinational from state and `imem_*` in FETCH, and registered in HOLD.
- Output latency from ack to `IR` valid is 0 cycles. IF/ID samples on the same edge.
- Stall handling:
  - While `stall`=1 in HOLD, outputs are bit-stable every cycle.
  - The first cycle with `stall`=0 still presents the buffered instruction; the next fetch request follows one cycle later.
- Redirect handling:
  - With no request outstanding, or with ack in the same cycle, the target is requested in the next cycle.
  - Otherwise the target is requested the cycle after the stale ack.
- `stall` in FETCH without ack has no effect.

## Test plan
- Reset: hold `reset`=0, drive `imem_ack`=1 → `imem_req`=0, `IR`=0, `PC`=0, `if_valid`=0. Release → `imem_req`=1 with `imem_addr`=0x0 in the cycle after the first edge.
- Streaming: ack every cycle, rdata 0x20080005/0x20090003/0x01095020 → `imem_addr` 0x0, 0x4, 0x8; `PC` 0x4, 0x8, 0xC; `if_valid`=1 each cycle.
- Stall hold: ack at 0x8 with rdata 0xAC0A0000 while `stall`=1 for 3 cycles:
  - `IR`=0xAC0A0000, `PC`=0xC on the ack cycle and all 3 HOLD cycles.
  - `imem_req`=0 in HOLD.
  - `stall` drops → the buffer is presented one more cycle, then a request to 0xC.
- Redirect during wait: request at 0x10 with no ack, `redirect`=1 with `redirect_pc`=0x400:
  - `imem_addr` stays 0x10 for 2 more cycles; ack arrives → `if_valid`=0.
  - Next request goes to 0x400.
- Redirect + stall in HOLD: `redirect_pc`=0x200 → `if_valid`=0 that cycle, next `imem_addr`=0x200 regardless of `stall`.
- Wrap/align: redirect to 0xFFFFFFFE → `imem_addr`=0xFFFFFFFC. Ack → `PC`=0x00000000, next `imem_addr`=0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : MIPS32 instruction-fetch stage (PC, imem req/ack, stall hold, redirect drop)
// Revision  : 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic [31:0] buf_ir;
  logic [31:0] buf_pc;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_target   = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4 = pc_q + 32'd4;

  // The address is held at pc_q for the whole request, including DROP.
  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = pc_q;

  // Live path in FETCH, buffered path in HOLD; a redirect squashes either.
  always_comb begin
    IR       = NOP_INSTR;
    PC       = 32'd0;
    if_valid = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack && !redirect) begin
          IR       = imem_rdata;
          PC       = w_pc_plus4;
          if_valid = 1'b1;
        end
      end
      HOLD: begin
        if (!redirect) begin
          IR       = buf_ir;
          PC       = buf_pc;
          if_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      buf_ir  <= 32'd0;
      buf_pc  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              pc_q <= w_target;
            end else begin
              pend_q  <= w_target;
              state_q <= DROP;
            end
          end else if (imem_ack) begin
            pc_q <= w_pc_plus4;
            if (stall) begin
              buf_ir  <= imem_rdata;
              buf_pc  <= w_pc_plus4;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q    <= w_target;
            state_q <= FETCH;
          end else if (!stall) begin
            state_q <= FETCH;
          end
        end
        DROP: begin
          // The stale word is discarded; the newest redirect target wins.
          if (imem_ack) begin
            pc_q    <= redirect ? w_target : pend_q;
            state_q <= FETCH;
          end else if (redirect) begin
            pend_q <= w_target;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
